fle_fabric_param: RTL and testbench
===================================

Name: fle_fabric_param

Overview:
- Parametrised successor of the CLB fle fabric primitive: N_OUT K-input LUTs sharing one input bus, one flip-flop per output and a 4-way output select per output.
- Adds features the current fabric lacks: per-FF clock-enable use, FF init load, a bypass path and a constant-0 path.
- Adds a single-clock configuration chain with a shift-enable, a bit counter and a configuration-valid flag.
- Sits inside the CLB between local routing and the CLB output muxes; chains head-to-tail with neighbouring fabric instances.

Parameters:
- K, 4, LUT input count (2..6).
- N_OUT, 2, number of LUT/FF/output slices (1..8).
- W (derived), 2**K+4, config bits per slice.
- CHAIN_LEN (derived), N_OUT*W, total config bits.

Ports:
- clk  input  1  sole clock; shifts config and clocks the FFs.
- reset  input  1  asynchronous, active-high; clears all state.
- fabric_in  input  K  LUT inputs; fabric_in[0] is the LSB of the LUT index.
- fabric_ce  input  1  FF clock enable, honoured only where ce_use=1.
- cfg_en  input  1  1 = shift the config chain this cycle.
- ccff_head  input  1  config serial in.
- fabric_out  output  N_OUT  slice outputs.
- ccff_tail  output  1  config serial out; equals cfg[CHAIN_LEN-1].
- cfg_ok  output  1  1 = last shift session was exactly CHAIN_LEN bits.

Behaviour:
- Config register cfg[0:CHAIN_LEN-1]:
  - On a shift: cfg[0]<=ccff_head; cfg[i]<=cfg[i-1].
  - The first bit shifted in lands at CHAIN_LEN-1.
- Slice j occupies cfg[j*W +: W]. Offsets within the slice:
  - 0..2**K-1: truth table; the LUT output is table[fabric_in].
  - 2**K..2**K+1: sel, with 2**K as the LSB.
  - 2**K+2: init.
  - 2**K+3: ce_use.
- sel decode:
  - 00: comb, fabric_out[j]=lut[j], 0-cycle latency.
  - 01: reg, fabric_out[j]=ff[j].
  - 10: bypass, fabric_out[j]=fabric_in[j mod K].
  - 11: constant 0.
- FSM states: UNCFG, SHIFT, LOAD, RUN.
  - UNCFG (reset state): FFs held at 0. cfg_en=1 -> SHIFT.
  - SHIFT: one shift per clk while cfg_en=1. bit_cnt increments and saturates at CHAIN_LEN+1. cfg_en=0 -> LOAD.
  - LOAD (exactly 1 cycle): ff[j]<=init_j; cfg_ok<=(bit_cnt==CHAIN_LEN). -> RUN, or -> SHIFT if cfg_en=1.
  - RUN: ff[j]<=lut[j] when (ce_use_j==0 or fabric_ce==1). cfg_en=1 -> SHIFT, bit_cnt cleared on entry.
  - The shift occurs on the same edge that enters SHIFT, so the first bit is counted.
- Output gating:
  - fabric_out is forced all-0 combinationally in every state except RUN.
  - In RUN, fabric_out follows sel regardless of cfg_ok.
- FFs do not capture in SHIFT; they hold their value.
- cfg_ok is cleared on entering SHIFT. It is updated only in LOAD and holds in RUN.
- reset, asynchronous at any time including mid-shift:
  - cfg, ff, bit_cnt and cfg_ok all go to 0; state -> UNCFG.
  - fabric_out=0 and ccff_tail=0 immediately, without waiting for a clk edge.
- Simultaneous cfg_en=1 and fabric_ce=1 in RUN: the shift wins; FFs hold.
- ccff_tail is unaffected by the FSM state; it always reflects cfg[CHAIN_LEN-1].
- bit_cnt width is clog2(CHAIN_LEN+2).

Test Plan (K=4, N_OUT=2, CHAIN_LEN=40):
1. Pulse reset; hold cfg_en=0 and toggle fabric_in -> fabric_out=2'b00, ccff_tail=0, cfg_ok=0 throughout.
2. Shift 40 bits. Slice0: table 16'h8000, sel 00. Slice1: table 16'h6996, sel 01, init 1, ce_use 1. Then drop cfg_en:
   - The cycle after LOAD: cfg_ok=1, fabric_out[1]=1.
   - fabric_in=4'hF -> fabric_out[0]=1 the same cycle.
   - fabric_out[1] stays 1 while fabric_ce=0.
   - One fabric_ce pulse -> fabric_out[1]=0 (parity of F).
3. Same as test 2 but with 39 and then 41 shifts -> cfg_ok=0 after LOAD in both cases; outputs still live in RUN.
4. Slice1 sel=10:
   - fabric_in=4'b0010 -> fabric_out[1]=1; 4'b0000 -> 0.
   - Slice0 sel=11 -> fabric_out[0]=0 for all 16 input values.
5. Assert reset after 20 shifts while ccff_tail=1 -> fabric_out=0 and ccff_tail=0 before the next clk edge; a re-shift of 40 bits restores cfg_ok=1.
6. In RUN, start a new shift session:
   - fabric_out=0 from the first SHIFT cycle and the FFs hold.
   - After 40 more shifts, ccff_tail emits the previous image's bit 0 first, in shift order.

Source files
------------

// File: rtl/fle_fabric_param.sv
// Parametrised CLB fabric slice array: N_OUT K-input LUTs with per-output FFs and output select,
// configured through a single serial chain with bit counting and a configuration-valid flag.
module fle_fabric_param #(
  parameter int K     = 4,
  parameter int N_OUT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [K-1:0]     fabric_in,
  input  logic             fabric_ce,
  input  logic             cfg_en,
  input  logic             ccff_head,
  output logic [N_OUT-1:0] fabric_out,
  output logic             ccff_tail,
  output logic             cfg_ok
);

  localparam int W         = 2**K + 4;
  localparam int CHAIN_LEN = N_OUT * W;
  localparam int CW        = $clog2(CHAIN_LEN + 2);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(CHAIN_LEN);
  localparam logic [CW-1:0] CNT_SAT  = CW'(CHAIN_LEN + 1);

  typedef enum logic [1:0] {UNCFG, SHIFT, LOAD, RUN} state_e;

  state_e                 state_q, state_d;
  logic [CHAIN_LEN-1:0]   cfg_q, cfg_d;
  logic [N_OUT-1:0]       ff_q, ff_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   ok_q, ok_d;

  logic [N_OUT-1:0]       lut_v, init_v, ce_use_v, sel_out_v;

  // Decode each slice's configuration word into its LUT result and selected output.
  for (genvar gj = 0; gj < N_OUT; gj++) begin : g_slice
    logic [W-1:0]      slice_w;
    logic [2**K-1:0]   table_w;
    logic [1:0]        sel_w;

    assign slice_w      = cfg_q[gj*W +: W];
    assign table_w      = slice_w[2**K-1:0];
    assign sel_w        = slice_w[2**K +: 2];
    assign init_v[gj]   = slice_w[2**K+2];
    assign ce_use_v[gj] = slice_w[2**K+3];
    assign lut_v[gj]    = table_w[fabric_in];

    always_comb begin
      sel_out_v[gj] = 1'b0;
      case (sel_w)
        2'b00:   sel_out_v[gj] = lut_v[gj];
        2'b01:   sel_out_v[gj] = ff_q[gj];
        2'b10:   sel_out_v[gj] = fabric_in[gj % K];
        default: sel_out_v[gj] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= UNCFG;
      cfg_q   <= '0;
      ff_q    <= '0;
      cnt_q   <= '0;
      ok_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      ff_q    <= ff_d;
      cnt_q   <= cnt_d;
      ok_q    <= ok_d;
    end
  end

  // The chain shifts on every cfg_en cycle; entering SHIFT counts that first bit as 1.
  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    ff_d    = ff_q;
    cnt_d   = cnt_q;
    ok_d    = ok_q;
    if (cfg_en) begin
      cfg_d = {cfg_q[CHAIN_LEN-2:0], ccff_head};
    end
    case (state_q)
      UNCFG: begin
        ff_d = '0;
        if (cfg_en) begin
          state_d = SHIFT;
          cnt_d   = CNT_ONE;
          ok_d    = 1'b0;
        end
      end
      SHIFT: begin
        if (cfg_en) begin
          if (cnt_q != CNT_SAT) begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        ff_d = init_v;
        ok_d = (cnt_q == CNT_FULL);
        if (cfg_en) begin
          state_d = SHIFT;
          cnt_d   = CNT_ONE;
          ok_d    = 1'b0;
        end else begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (cfg_en) begin
          state_d = SHIFT;
          cnt_d   = CNT_ONE;
          ok_d    = 1'b0;
        end else begin
          for (int j = 0; j < N_OUT; j++) begin
            if (!ce_use_v[j] || fabric_ce) begin
              ff_d[j] = lut_v[j];
            end
          end
        end
      end
      default: state_d = UNCFG;
    endcase
  end

  assign fabric_out = (state_q == RUN) ? sel_out_v : '0;
  assign ccff_tail  = cfg_q[CHAIN_LEN-1];
  assign cfg_ok     = ok_q;

endmodule

// File: tb/tb_fle_fabric_param.sv
// Directed self-checking bench for fle_fabric_param with K=4, N_OUT=2 (40-bit chain).
module tb_fle_fabric_param;

  logic       clk;
  logic       reset;
  logic [3:0] fabric_in;
  logic       fabric_ce;
  logic       cfg_en;
  logic       ccff_head;
  logic [1:0] fabric_out;
  logic       ccff_tail;
  logic       cfg_ok;

  int nCompared;
  int nMismatched;

  // Slice word layout, MSB first: {ce_use, init, sel[1:0], table[15:0]}; image = {slice1, slice0}.
  localparam logic [39:0] IMG_A = {1'b1, 1'b1, 2'b01, 16'h6996, 1'b0, 1'b0, 2'b00, 16'h8000};
  localparam logic [39:0] IMG_B = {1'b0, 1'b0, 2'b10, 16'h0000, 1'b1, 1'b0, 2'b11, 16'h8000};

  fle_fabric_param #(.K(4), .N_OUT(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .fabric_in  (fabric_in),
    .fabric_ce  (fabric_ce),
    .cfg_en     (cfg_en),
    .ccff_head  (ccff_head),
    .fabric_out (fabric_out),
    .ccff_tail  (ccff_tail),
    .cfg_ok     (cfg_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Shifts n bits; n=40 loads img exactly, n=41 prepends one junk 0, n=39 drops img[39].
  task automatic shift_image(input logic [39:0] img, input int n);
    for (int s = 0; s < n; s++) begin
      int idx;
      idx = 39 - s + (n - 40);
      @(negedge clk);
      cfg_en    = 1'b1;
      ccff_head = (idx >= 0 && idx <= 39) ? img[idx] : 1'b0;
    end
  endtask

  // Drops cfg_en, checks the LOAD cycle is gated, and returns at the first RUN negedge.
  task automatic end_session();
    @(negedge clk);
    cfg_en    = 1'b0;
    ccff_head = 1'b0;
    @(negedge clk);
    #1;
    nCompared++;
    if (fabric_out !== 2'b00) begin nMismatched++; $display("[TB] FAIL load_gate: got %b expected 00", fabric_out); end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; fabric_in = 4'h0; fabric_ce = 1'b0; cfg_en = 1'b0; ccff_head = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int v = 0; v < 4; v++) begin
      @(negedge clk);
      fabric_in = 4'(v * 5);
      #1;
      nCompared++;
      if (fabric_out !== 2'b00) begin nMismatched++; $display("[TB] FAIL uncfg_out: got %b expected 00", fabric_out); end
      nCompared++;
      if (ccff_tail !== 1'b0) begin nMismatched++; $display("[TB] FAIL uncfg_tail: got %b expected 0", ccff_tail); end
      nCompared++;
      if (cfg_ok !== 1'b0) begin nMismatched++; $display("[TB] FAIL uncfg_ok: got %b expected 0", cfg_ok); end
    end
    fabric_in = 4'h0;
  endtask

  task automatic test_config_run();
    shift_image(IMG_A, 40);
    end_session();
    nCompared++;
    if (cfg_ok !== 1'b1) begin nMismatched++; $display("[TB] FAIL cfg_ok40: got %b expected 1", cfg_ok); end
    nCompared++;
    if (fabric_out !== 2'b10) begin nMismatched++; $display("[TB] FAIL run_init: got %b expected 10", fabric_out); end
    fabric_in = 4'hF;
    #1;
    nCompared++;
    if (fabric_out[0] !== 1'b1) begin nMismatched++; $display("[TB] FAIL and_comb: got %b expected 1", fabric_out[0]); end
    @(negedge clk);
    nCompared++;
    if (fabric_out[1] !== 1'b1) begin nMismatched++; $display("[TB] FAIL ce_hold: got %b expected 1", fabric_out[1]); end
    fabric_ce = 1'b1;
    @(negedge clk);
    fabric_ce = 1'b0;
    #1;
    nCompared++;
    if (fabric_out[1] !== 1'b0) begin nMismatched++; $display("[TB] FAIL ce_capture: got %b expected 0", fabric_out[1]); end
    fabric_in = 4'h7;
    #1;
    nCompared++;
    if (fabric_out !== 2'b00) begin nMismatched++; $display("[TB] FAIL and_miss: got %b expected 00", fabric_out); end
    fabric_in = 4'h0;
  endtask

  task automatic test_bad_length();
    for (int t = 0; t < 2; t++) begin
      shift_image(IMG_A, (t == 0) ? 39 : 41);
      end_session();
      fabric_in = 4'hF;
      #1;
      nCompared++;
      if (cfg_ok !== 1'b0) begin nMismatched++; $display("[TB] FAIL cfg_ok_len%0d: got %b expected 0", t, cfg_ok); end
      nCompared++;
      if (fabric_out !== 2'b11) begin nMismatched++; $display("[TB] FAIL live_len%0d: got %b expected 11", t, fabric_out); end
      fabric_in = 4'h0;
    end
  endtask

  task automatic test_bypass_const();
    shift_image(IMG_B, 40);
    end_session();
    fabric_in = 4'b0010;
    #1;
    nCompared++;
    if (fabric_out[1] !== 1'b1) begin nMismatched++; $display("[TB] FAIL bypass_hi: got %b expected 1", fabric_out[1]); end
    fabric_in = 4'b0000;
    #1;
    nCompared++;
    if (fabric_out[1] !== 1'b0) begin nMismatched++; $display("[TB] FAIL bypass_lo: got %b expected 0", fabric_out[1]); end
    fabric_in = 4'b1101;
    #1;
    nCompared++;
    if (fabric_out[1] !== 1'b0) begin nMismatched++; $display("[TB] FAIL bypass_bit1: got %b expected 0", fabric_out[1]); end
    for (int v = 0; v < 16; v++) begin
      fabric_in = 4'(v);
      #1;
      nCompared++;
      if (fabric_out[0] !== 1'b0) begin nMismatched++; $display("[TB] FAIL const0_in%0d: got %b expected 0", v, fabric_out[0]); end
    end
    fabric_in = 4'h0;
  endtask

  task automatic test_async_reset();
    shift_image(40'h0, 20);
    @(negedge clk);
    cfg_en = 1'b0;
    nCompared++;
    if (ccff_tail !== 1'b1) begin nMismatched++; $display("[TB] FAIL tail_pre_reset: got %b expected 1", ccff_tail); end
    #1;
    reset = 1'b1;
    #1;
    nCompared++;
    if (ccff_tail !== 1'b0) begin nMismatched++; $display("[TB] FAIL tail_async: got %b expected 0", ccff_tail); end
    nCompared++;
    if (fabric_out !== 2'b00) begin nMismatched++; $display("[TB] FAIL out_async: got %b expected 00", fabric_out); end
    @(negedge clk);
    reset = 1'b0;
    shift_image(IMG_A, 40);
    end_session();
    nCompared++;
    if (cfg_ok !== 1'b1) begin nMismatched++; $display("[TB] FAIL cfg_ok_reshift: got %b expected 1", cfg_ok); end
  endtask

  task automatic test_back_to_back();
    fabric_in = 4'hF;
    fabric_ce = 1'b1;
    for (int s = 0; s < 40; s++) begin
      @(negedge clk);
      cfg_en    = 1'b1;
      ccff_head = IMG_B[39-s];
      #1;
      nCompared++;
      if (ccff_tail !== IMG_A[39-s]) begin nMismatched++; $display("[TB] FAIL tail_order%0d: got %b expected %b", s, ccff_tail, IMG_A[39-s]); end
      if (s > 0) begin
        nCompared++;
        if (fabric_out !== 2'b00) begin nMismatched++; $display("[TB] FAIL shift_gate%0d: got %b expected 00", s, fabric_out); end
        nCompared++;
        if (cfg_ok !== 1'b0) begin nMismatched++; $display("[TB] FAIL shift_ok%0d: got %b expected 0", s, cfg_ok); end
      end
    end
    fabric_ce = 1'b0;
    end_session();
    nCompared++;
    if (cfg_ok !== 1'b1) begin nMismatched++; $display("[TB] FAIL cfg_ok_b2b: got %b expected 1", cfg_ok); end
    nCompared++;
    if (ccff_tail !== IMG_B[39]) begin nMismatched++; $display("[TB] FAIL tail_new: got %b expected %b", ccff_tail, IMG_B[39]); end
    nCompared++;
    if (fabric_out !== 2'b10) begin nMismatched++; $display("[TB] FAIL run_new: got %b expected 10", fabric_out); end
  endtask

  initial begin
    nCompared   = 0;
    nMismatched = 0;
    test_reset();
    test_config_run();
    test_bad_length();
    test_bypass_const();
    test_async_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
